// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port synchronous memory between the instruction-fetch
// port and the load/store port; D has priority, with a starvation guard for IF.
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_gnt_o,
  output logic        if_rvalid_o,
  output logic [31:0] if_rdata_o,
  output logic        if_err_o,
  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  output logic        d_gnt_o,
  output logic        d_rvalid_o,
  output logic [31:0] d_rdata_o,
  output logic        d_err_o,
  output logic        mem_en_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] starveCnt_q, starveCnt_d;
  logic             ownerD_q, ownerD_d;
  logic             we_q, we_d;
  logic             err_q, err_d;
  logic             memEn_q, memEn_d;
  logic             memWe_q, memWe_d;
  logic [31:0]      memAddr_q, memAddr_d;
  logic [31:0]      memWdata_q, memWdata_d;

  logic        acceptPt, dWins, ifWins, grant;
  logic        selWe, selAligned;
  logic [31:0] selAddr, selWdata, respData;

  // Arbitration is only open in IDLE and RESP, which lets RESP overlap a new grant.
  always_comb begin
    acceptPt   = !rst && (state_q == IDLE || state_q == RESP);
    dWins      = acceptPt && d_req_i && (!if_req_i || starveCnt_q < LIMIT);
    ifWins     = acceptPt && if_req_i && !dWins;
    grant      = dWins || ifWins;
    selAddr    = dWins ? d_addr_i : if_addr_i;
    selWe      = dWins && d_we_i;
    selWdata   = dWins ? d_wdata_i : 32'h0;
    selAligned = (selAddr[1:0] == 2'b00);
  end

  always_comb begin
    state_d     = state_q;
    starveCnt_d = starveCnt_q;
    ownerD_d    = ownerD_q;
    we_d        = we_q;
    err_d       = err_q;
    memEn_d     = 1'b0;
    memWe_d     = 1'b0;
    memAddr_d   = 32'h0;
    memWdata_d  = 32'h0;
    case (state_q)
      IDLE, RESP: begin
        if (grant) begin
          state_d  = ACCESS;
          ownerD_d = dWins;
          we_d     = selWe;
          err_d    = !selAligned;
          // Memory strobes are prepared here so they appear registered in ACCESS.
          if (selAligned) begin
            memEn_d    = 1'b1;
            memWe_d    = selWe;
            memAddr_d  = selAddr;
            memWdata_d = selWdata;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS:  state_d = RESP;
      default: state_d = IDLE;
    endcase
    if (acceptPt) begin
      if (ifWins || !if_req_i) begin
        starveCnt_d = '0;
      end else if (dWins && starveCnt_q < LIMIT) begin
        starveCnt_d = starveCnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      starveCnt_q <= '0;
      ownerD_q    <= 1'b0;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      memEn_q     <= 1'b0;
      memWe_q     <= 1'b0;
      memAddr_q   <= 32'h0;
      memWdata_q  <= 32'h0;
    end else begin
      state_q     <= state_d;
      starveCnt_q <= starveCnt_d;
      ownerD_q    <= ownerD_d;
      we_q        <= we_d;
      err_q       <= err_d;
      memEn_q     <= memEn_d;
      memWe_q     <= memWe_d;
      memAddr_q   <= memAddr_d;
      memWdata_q  <= memWdata_d;
    end
  end

  always_comb begin
    respData    = (!we_q && !err_q) ? mem_rdata_i : 32'h0;
    if_rvalid_o = (state_q == RESP) && !ownerD_q;
    d_rvalid_o  = (state_q == RESP) && ownerD_q;
    if_rdata_o  = if_rvalid_o ? respData : 32'h0;
    d_rdata_o   = d_rvalid_o ? respData : 32'h0;
    if_err_o    = if_rvalid_o && err_q;
    d_err_o     = d_rvalid_o && err_q;
  end

  assign if_gnt_o    = ifWins;
  assign d_gnt_o     = dWins;
  assign mem_en_o    = memEn_q;
  assign mem_we_o    = memWe_q;
  assign mem_addr_o  = memAddr_q;
  assign mem_wdata_o = memWdata_q;

endmodule
